muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand width; legal values are even integers 4..64.
REQ-002 clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 start  input  1  SHALL be the operation request, sampled only in IDLE.
REQ-005 op  input  2  SHALL select the operation: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-006 A  input  WIDTH  SHALL be the multiplicand or dividend.
REQ-007 B  input  WIDTH  SHALL be the multiplier or divisor.
REQ-008 busy  output  1  SHALL be high in every state except IDLE.
REQ-009 done  output  1  SHALL be a one-cycle completion pulse.
REQ-010 div_0_exception  output  1  SHALL be a one-cycle pulse, coincident with done, on divide by zero.
REQ-011 HI  output  WIDTH  SHALL hold the product upper half or the remainder.
REQ-012 LO  output  WIDTH  SHALL hold the product lower half or the quotient.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, CALC, FIX and DONE.
REQ-014 In IDLE with start=1, the block SHALL latch op, A and B, and go to CALC next cycle.
REQ-015 An exception: in IDLE with start=1 and op[1]=1 and B=0, the block SHALL go directly to DONE and skip CALC.
REQ-016 For signed ops, CALC SHALL operate on operand magnitudes and record the result signs at latch time.
REQ-017 CALC SHALL last exactly WIDTH cycles, counted by an internal counter of ceil(log2(WIDTH+1)) bits.
REQ-018 Each CALC cycle SHALL perform one radix-2 step: shift-add for MULT, restoring shift-subtract for DIV.
REQ-019 FIX SHALL last one cycle and apply the sign correction; FIX is executed for unsigned ops too.
REQ-020 Multiply: {HI,LO} SHALL equal the exact 2*WIDTH-bit product, two's complement for MULT.
REQ-021 Divide: LO SHALL be the quotient truncated toward zero, and HI the remainder with the sign of the dividend.
REQ-022 Signed divide of MIN by -1 SHALL give LO=MIN and HI=0, with no exception raised.
REQ-023 Latency: with start sampled at edge n, done SHALL be high during cycle n+WIDTH+2.
REQ-024 Results: HI and LO SHALL be updated at entry to DONE and held stable until the next normal-completion DONE.
REQ-025 Divide-by-zero path: done and div_0_exception SHALL be high during cycle n+1, and HI and LO SHALL be unchanged.
REQ-026 DONE SHALL last one cycle and return to IDLE; a start in DONE SHALL be ignored.
REQ-027 start SHALL be ignored while busy=1; latched operands SHALL not change during an operation.
REQ-028 A start in the cycle immediately after DONE (IDLE) SHALL be accepted, giving back-to-back throughput of WIDTH+3 cycles.
REQ-029 Outside DONE, done and div_0_exception SHALL be 0.
REQ-030 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-031 With reset=1 at any edge, the state SHALL go to IDLE, and busy, done, div_0_exception, HI, LO, the counter and all internal registers SHALL go to 0.
REQ-032 A reset during CALC or FIX SHALL abort the operation, and no done pulse SHALL follow.
REQ-033 reset SHALL take priority over start in the same cycle.

Verification (WIDTH=32; start at edge n)
REQ-034 Directed scenarios:
- MULT A=FFFFFFFD (-3), B=00000005 -> done at n+34; HI=FFFFFFFF, LO=FFFFFFF1; busy is high n+1..n+34.
- MULTU A=FFFFFFFF, B=FFFFFFFF -> HI=FFFFFFFE, LO=00000001 at n+34.
- DIV A=FFFFFFF9 (-7), B=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF; DIV A=80000000, B=FFFFFFFF -> LO=80000000, HI=00000000, no exception.
- DIVU A=00000064, B=0 after a prior result HI=1, LO=2 -> done=div_0_exception=1 at n+1 only; HI=1, LO=2 retained.
- MULTU 7x9 with a second start at n+5 (A=1, B=1) -> second start ignored; HI=0, LO=0000003F at n+34; a start at n+35 is accepted and done follows at n+69.
- Reset at n+10 during DIVU 100/7 -> IDLE, HI=LO=0, busy=0 next cycle, no done pulse for 40 cycles.

Source files
------------

// File: rtl/muldiv_if.sv
// Request/result bundle for the iterative multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             div_0_exception;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output start, op, A, B,
                  input  busy, done, div_0_exception, HI, LO);
  modport slave  (input  start, op, A, B,
                  output busy, done, div_0_exception, HI, LO);
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiplier/divider: WIDTH calc steps on magnitudes, one
// sign-fix cycle, one done cycle. Divide by zero short-cuts straight to DONE.
module muldiv_unit #(parameter int WIDTH = 32) (
  input logic     clock,
  input logic     reset,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_m, r_HI, r_LO;
  logic             r_div, r_negq, r_negr, r_busy, r_done, r_dz;

  logic             w_sa, w_sb, w_ge;
  logic [WIDTH-1:0] w_maga, w_magb, w_sub;
  logic [WIDTH:0]   w_sum, w_shift;
  logic [2*WIDTH-1:0] w_fix;

  assign w_sa   = ~bus.op[0] & bus.A[WIDTH-1];
  assign w_sb   = ~bus.op[0] & bus.B[WIDTH-1];
  assign w_maga = w_sa ? -bus.A : bus.A;
  assign w_magb = w_sb ? -bus.B : bus.B;

  // Multiply: add multiplicand when multiplier LSB is set, then shift {hi,lo} right.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
  // Divide: shift next dividend bit into the partial remainder, subtract if it fits.
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_m};
  assign w_sub   = w_shift[WIDTH-1:0] - r_m;

  always_comb begin
    w_fix = {r_hi, r_lo};
    if (!r_div) begin
      if (r_negq) w_fix = -{r_hi, r_lo};
    end else begin
      w_fix[WIDTH-1:0]       = r_negq ? -r_lo : r_lo;
      w_fix[2*WIDTH-1:WIDTH] = r_negr ? -r_hi : r_hi;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_m     <= '0;
      r_HI    <= '0;
      r_LO    <= '0;
      r_div   <= 1'b0;
      r_negq  <= 1'b0;
      r_negr  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_busy <= 1'b1;
          if (bus.op[1] && bus.B == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_dz    <= 1'b1;
          end else begin
            r_state <= CALC;
            r_div   <= bus.op[1];
            r_negq  <= w_sa ^ w_sb;
            r_negr  <= w_sa;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= bus.op[1] ? w_maga : w_magb;
            r_m     <= bus.op[1] ? w_magb : w_maga;
          end
        end
        CALC: begin
          if (r_div) begin
            r_hi <= w_ge ? w_sub : w_shift[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_ge};
          end else begin
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) r_state <= FIX;
        end
        FIX: begin
          r_HI    <= w_fix[2*WIDTH-1:WIDTH];
          r_LO    <= w_fix[WIDTH-1:0];
          r_cnt   <= '0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.div_0_exception = r_dz;
  assign bus.HI              = r_HI;
  assign bus.LO              = r_LO;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized bench for muldiv_unit (WIDTH=32) against an arithmetic reference.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   fails   = 0;

  muldiv_if #(.WIDTH(W)) bus();
  muldiv_unit #(.WIDTH(W)) dut (.clock(clk), .reset(rst), .bus(bus));

  always #5 clk = ~clk;

  // Exact result from plain arithmetic, returned as {HI, LO}.
  function automatic logic [63:0] ref_res(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: return 64'(sa * sb);
      2'b01: return 64'(ua * ub);
      2'b10: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        ua = {32'd0, a} / {32'd0, b};
        ub = {32'd0, a} % {32'd0, b};
        return {ub[31:0], ua[31:0]};
      end
    endcase
  endfunction

  // Cycle-level expectation: after an accepted start, done arrives W+2 cycles later
  // (or next cycle for divide by zero), then one more cycle back to idle.
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [31:0] m_HI = '0, m_LO = '0;
  logic [63:0] m_res = '0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_HI = '0; m_LO = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (!m_busy) begin
        if (bus.start) begin
          m_busy = 1'b1;
          if (bus.op[1] && bus.B == 32'd0) begin
            m_done = 1'b1; m_dz = 1'b1; m_left = 0;
          end else begin
            m_left = W + 1;
            m_res  = ref_res(bus.op, bus.A, bus.B);
          end
        end
      end else if (m_left == 0) begin
        m_busy = 1'b0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          {m_HI, m_LO} = m_res;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.div_0_exception, bus.HI, bus.LO} !==
        {m_busy, m_done, m_dz, m_HI, m_LO}) begin
      fails++;
      $display("FAIL cycle_cmp t=%0t got busy=%b done=%b dz=%b HI=%h LO=%h want busy=%b done=%b dz=%b HI=%h LO=%h",
               $time, bus.busy, bus.done, bus.div_0_exception, bus.HI, bus.LO,
               m_busy, m_done, m_dz, m_HI, m_LO);
    end
  end

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  // Present a start for one edge; returns in the first busy cycle.
  task automatic go(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  logic [31:0] ra, rb;
  int          ndone;

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.A = '0; bus.B = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {bus.busy, bus.done, bus.div_0_exception, bus.HI, bus.LO}, '0);

    // MULT -3 * 5
    go(2'b00, 32'hFFFFFFFD, 32'h00000005);
    chk("mult_busy_n1", {63'd0, bus.busy}, 64'd1);
    repeat (32) @(negedge clk);
    chk("mult_no_early_done", {63'd0, bus.done}, 64'd0);
    @(negedge clk);
    chk("mult_done_n34", {63'd0, bus.done}, 64'd1);
    chk("mult_result", {bus.HI, bus.LO}, 64'hFFFFFFFF_FFFFFFF1);
    @(negedge clk);
    chk("mult_idle_n35", {62'd0, bus.busy, bus.done}, 64'd0);

    go(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (33) @(negedge clk);
    chk("multu_result", {bus.HI, bus.LO}, 64'hFFFFFFFE_00000001);

    go(2'b10, 32'hFFFFFFF9, 32'h00000002);
    repeat (33) @(negedge clk);
    chk("div_neg7_2", {bus.HI, bus.LO}, 64'hFFFFFFFF_FFFFFFFD);

    go(2'b10, 32'h80000000, 32'hFFFFFFFF);
    repeat (33) @(negedge clk);
    chk("div_min_m1", {bus.HI, bus.LO}, 64'h00000000_80000000);
    chk("div_min_m1_flags", {62'd0, bus.done, bus.div_0_exception}, 64'd2);

    // Prior result HI=1, LO=2, then divide by zero must leave it untouched.
    go(2'b11, 32'd7, 32'd3);
    repeat (34) @(negedge clk);
    chk("divu_7_3", {bus.HI, bus.LO}, 64'h00000001_00000002);
    go(2'b11, 32'd100, 32'd0);
    chk("dz_flags_n1", {62'd0, bus.done, bus.div_0_exception}, 64'd3);
    chk("dz_hold", {bus.HI, bus.LO}, 64'h00000001_00000002);
    @(negedge clk);
    chk("dz_flags_n2", {61'd0, bus.busy, bus.done, bus.div_0_exception}, 64'd0);

    // Start while busy is ignored; start right after DONE is accepted.
    go(2'b01, 32'd7, 32'd9);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.A = 32'd1; bus.B = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    chk("ignore_start_done", {63'd0, bus.done}, 64'd1);
    chk("ignore_start_res", {bus.HI, bus.LO}, 64'h00000000_0000003F);
    go(2'b01, 32'd3, 32'd4);
    repeat (33) @(negedge clk);
    chk("b2b_done_n69", {63'd0, bus.done}, 64'd1);
    chk("b2b_res", {bus.HI, bus.LO}, 64'h00000000_0000000C);

    // Reset in the middle of DIVU 100/7.
    @(negedge clk);
    go(2'b11, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", {bus.busy, bus.done, bus.div_0_exception, bus.HI, bus.LO}, '0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    // Randomized traffic, including starts while busy, corner operands and resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: ra = 32'($urandom_range(0, 20));
        2: ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 20));
        3: rb = 32'h80000000;
        default: rb = $urandom;
      endcase
      bus.A = ra;
      bus.B = rb;
    end
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
